// File: rtl/uart_tx_peripheral_if.sv
// Data-memory bus as seen by the UART transmitter peripheral.
// The master drives the bus and the peripheral returns load data.
interface uart_tx_peripheral_if;
  logic        sel;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic        wmem;
  logic [2:0]  func3;
  logic [63:0] rdata;

  modport master (
    output sel,
    output addr,
    output wdata,
    output wmem,
    output func3,
    input  rdata
  );

  modport slave (
    input  sel,
    input  addr,
    input  wdata,
    input  wmem,
    input  func3,
    output rdata
  );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO,
// a status register and a programmable bit period.
module uart_tx_peripheral #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] BAUDDIV_RST = 16'd867
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_peripheral_if.slave  bus,
  output logic                 tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic wr_en;
  logic hit_tx, hit_st, hit_div;
  logic full, empty, bit_end;
  logic push_req, push, pop;
  logic [63:0] status;
  logic unused_bits;

  assign wr_en   = bus.sel & bus.wmem;
  assign hit_tx  = bus.addr == 8'h00;
  assign hit_st  = bus.addr == 8'h08;
  assign hit_div = bus.addr == 8'h10;

  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign bit_end = baud_q == 16'd0;

  // A pop on the same edge frees the slot a full-FIFO push needs
  assign push_req = wr_en & hit_tx;
  assign push     = push_req & (~full | pop);

  assign unused_bits = ^{bus.wdata[63:16], bus.func3[2]};

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = div_q;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          baud_d  = div_q;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = div_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            baud_d  = div_q;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en & hit_st) begin
      ovf_d = 1'b0;
    end else if (push_req & ~push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_en & hit_div) begin
      if (bus.func3[1:0] == 2'b00) begin
        div_d = {div_q[15:8], bus.wdata[7:0]};
      end else begin
        div_d = bus.wdata[15:0];
      end
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[2]       = state_q != S_IDLE;
    status[3]       = ovf_q;
    status[8 +: CW] = cnt_q;
  end

  always_comb begin
    unique case (1'b1)
      hit_st:  bus.rdata = status;
      hit_div: bus.rdata = {48'd0, div_q};
      default: bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      div_q   <= BAUDDIV_RST;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Self-checking bench for uart_tx_peripheral: register vectors,
// a frame-timeline reference model and hand-written corner cases.
module tb_uart_tx_peripheral;

  logic clk = 1'b0;
  logic rst;
  logic tx;

  uart_tx_peripheral_if bus();

  uart_tx_peripheral #(
    .FIFO_DEPTH (8),
    .BAUDDIV_RST(16'd867)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .tx (tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // tx sample taken just after each rising edge while recording
  logic rec = 1'b0;
  logic txlog[$];
  always @(posedge clk) begin
    #2;
    if (rec) txlog.push_back(tx);
  end

  typedef struct {
    logic        we;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic [2:0]  f3;
    logic [7:0]  raddr;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[$];
  logic [7:0] sched_b[$];
  int         sched_gap[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.sel   = 1'b0;
    bus.wmem  = 1'b0;
    bus.addr  = 8'h00;
    bus.wdata = '0;
    bus.func3 = 3'b011;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d,
                    input logic [2:0] f3);
    bus.sel   = 1'b1;
    bus.wmem  = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.func3 = f3;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] v);
    bus.sel  = 1'b1;
    bus.wmem = 1'b0;
    bus.addr = a;
    #1;
    v = bus.rdata;
    bus_idle();
  endtask

  function automatic logic [63:0] mk_status(int cnt, bit ovf, bit busy);
    logic [63:0] s;
    s = 64'(cnt) << 8;
    s[0] = (cnt == 8);
    s[1] = (cnt == 0);
    s[2] = busy;
    s[3] = ovf;
    return s;
  endfunction

  // Model: a push at edge p is taken if the FIFO has room before the
  // edge or a frame begins (pops) at that edge; a frame begins at the
  // later of p+1 and the end of the previous frame.
  task automatic run_sched(input string nm, input int d);
    int pt[$];
    int st[$];
    logic [7:0] ab[$];
    int prevend, flen, cnt, npop, s, last, need, guard, mism, qcnt;
    bit ovf, busy;
    logic [63:0] v;
    logic [7:0] dec;
    logic e[];
    wr(8'h08, 64'h0, 3'b011);
    wr(8'h10, 64'(d), 3'b011);
    txlog.delete();
    rec = 1'b1;
    foreach (sched_b[k]) begin
      bus.sel        = 1'b1;
      bus.wmem       = 1'b1;
      bus.addr       = 8'h00;
      bus.wdata      = {$urandom(), $urandom()};
      bus.wdata[7:0] = sched_b[k];
      bus.func3      = 3'($urandom_range(0, 7));
      pt.push_back(txlog.size());
      @(negedge clk);
      bus_idle();
      if (k < sched_b.size() - 1) repeat (sched_gap[k]) @(negedge clk);
    end
    rd(8'h08, v);
    flen    = 10 * (d + 1);
    prevend = 0;
    ovf     = 1'b0;
    foreach (pt[k]) begin
      cnt  = ab.size();
      npop = 0;
      foreach (st[j]) begin
        if (st[j] < pt[k]) cnt--;
        if (st[j] == pt[k]) npop++;
      end
      if (cnt < 8 || npop > 0) begin
        s = (pt[k] + 1 > prevend) ? pt[k] + 1 : prevend;
        st.push_back(s);
        ab.push_back(sched_b[k]);
        prevend = s + flen;
      end else begin
        ovf = 1'b1;
      end
    end
    last = pt[pt.size() - 1];
    qcnt = ab.size();
    busy = 1'b0;
    foreach (st[j]) begin
      if (st[j] <= last) qcnt--;
      if (st[j] <= last && last < st[j] + flen) busy = 1'b1;
    end
    chk({nm, " status after writes"}, v, mk_status(qcnt, ovf, busy));
    need  = prevend + 3;
    guard = 0;
    while (txlog.size() < need && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    rec = 1'b0;
    if (txlog.size() < need) begin
      chk({nm, " timeout samples"}, 64'(txlog.size()), 64'(need));
      return;
    end
    e = new[need];
    foreach (e[i]) e[i] = 1'b1;
    foreach (st[j]) begin
      for (int c = 0; c < flen; c++) begin
        int b;
        b = c / (d + 1);
        e[st[j] + c] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ab[j][b-1];
      end
    end
    mism = 0;
    for (int i = 0; i < need; i++) if (txlog[i] !== e[i]) mism++;
    chk({nm, " tx waveform mismatches"}, 64'(mism), 64'h0);
    foreach (st[j]) begin
      for (int b = 0; b < 8; b++)
        dec[b] = txlog[st[j] + (b + 1) * (d + 1) + d / 2];
      chk($sformatf("%s byte %0d", nm, j), {56'h0, dec}, {56'h0, ab[j]});
    end
    rd(8'h08, v);
    chk({nm, " status at end"}, v, mk_status(0, ovf, 1'b0));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int ones, hi, n;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    ones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx === 1'b1) ones++;
    end
    chk("tx idle 100 cycles", 64'(ones), 64'd100);

    vt.push_back('{0, 8'h00, 64'h0, 3'd3, 8'h08, 64'h002, "status rst"});
    vt.push_back('{0, 8'h00, 64'h0, 3'd3, 8'h10, 64'd867, "div rst"});
    vt.push_back('{1, 8'h10, 64'h1234, 3'd3, 8'h10, 64'h1234, "div dw"});
    vt.push_back('{1, 8'h10, 64'hFFAB, 3'd0, 8'h10, 64'h12AB, "div byte"});
    vt.push_back('{1, 8'h10, 64'hFFFF_0007, 3'd1, 8'h10, 64'h7, "div half"});
    vt.push_back('{1, 8'h10, 64'hFFFF_FFFF_0000_BEEF, 3'd2, 8'h10,
                   64'hBEEF, "div word"});
    vt.push_back('{1, 8'h18, 64'h55, 3'd3, 8'h10, 64'hBEEF, "unmapped wr"});
    vt.push_back('{0, 8'h00, 64'h0, 3'd3, 8'h18, 64'h0, "unmapped rd"});
    vt.push_back('{1, 8'h08, 64'hFFFF, 3'd3, 8'h08, 64'h002, "status wr"});
    vt.push_back('{0, 8'h00, 64'h0, 3'd3, 8'h00, 64'h0, "txdata rd"});
    vt.push_back('{0, 8'h00, 64'h0, 3'd3, 8'h11, 64'h0, "offset 11"});
    vt.push_back('{1, 8'h10, 64'h3, 3'd3, 8'h10, 64'h3, "div 3"});
    foreach (vt[i]) begin
      if (vt[i].we) wr(vt[i].waddr, vt[i].wdata, vt[i].f3);
      rd(vt[i].raddr, v);
      chk(vt[i].nm, v, vt[i].exp);
    end

    sched_b = '{8'hA5};
    sched_gap = '{0};
    run_sched("a5 d3", 3);

    wr(8'h00, 64'h5A, 3'b000);
    rd(8'h08, v);
    chk("busy before pop", {63'h0, v[2]}, 64'h0);
    hi = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      rd(8'h08, v);
      if (k == 1) chk("busy at pop", {63'h0, v[2]}, 64'h1);
      if (v[2]) hi++;
    end
    chk("busy cycles d3", 64'(hi), 64'd40);

    sched_b.delete();
    sched_gap.delete();
    for (int k = 1; k <= 9; k++) begin
      sched_b.push_back(8'(k));
      sched_gap.push_back(0);
    end
    run_sched("nine d1", 1);

    sched_b.delete();
    sched_gap.delete();
    for (int k = 0; k < 12; k++) begin
      sched_b.push_back(8'h30 + 8'(k));
      sched_gap.push_back(0);
    end
    run_sched("full pop d0", 0);

    for (int r = 0; r < 3; r++) begin
      sched_b.delete();
      sched_gap.delete();
      n = $urandom_range(9, 16);
      for (int k = 0; k < n; k++) begin
        sched_b.push_back(8'($urandom()));
        sched_gap.push_back(($urandom_range(0, 3) == 0) ?
                            $urandom_range(1, 12) : 0);
      end
      run_sched($sformatf("rand%0d", r), $urandom_range(0, 2));
    end

    wr(8'h10, 64'd1000, 3'b011);
    for (int k = 0; k < 10; k++) begin
      bus.sel   = 1'b1;
      bus.wmem  = 1'b1;
      bus.addr  = 8'h00;
      bus.wdata = 64'(k + 1);
      bus.func3 = 3'b000;
      @(negedge clk);
    end
    bus_idle();
    rd(8'h08, v);
    chk("ovf status", v, 64'h80D);
    wr(8'h08, 64'h0, 3'b000);
    rd(8'h08, v);
    chk("ovf cleared", v, 64'h805);
    chk("tx low mid start", {63'h0, tx}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("tx after rst", {63'h0, tx}, 64'h1);
    rd(8'h08, v);
    chk("status after rst", v, 64'h002);
    rd(8'h10, v);
    chk("div after rst", v, 64'd867);
    rst = 1'b0;

    wr(8'h10, 64'h0102, 3'b011);
    wr(8'h00, 64'hF0, 3'b000);
    repeat (100) @(negedge clk);
    chk("tx low before div wr", {63'h0, tx}, 64'h0);
    wr(8'h10, 64'hFFFF_FF05, 3'b000);
    rd(8'h10, v);
    chk("div byte merge", v, 64'h0105);
    n = 101;
    while (tx === 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("first high sample", 64'(n), 64'd1308);
    rd(8'h08, v);
    chk("status mid frame", v, 64'h006);
    rst = 1'b1;
    @(negedge clk);
    rd(8'h08, v);
    chk("status rst mid frame", v, 64'h002);
    chk("tx rst mid frame", {63'h0, tx}, 64'h1);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
